vector_assembler: RTL and testbench

Upstream front-end for the debugger input port. It accepts a scalar element stream of one element per cycle from the instrumented datapath and packs it into N-lane vectors. It drives the debugger's `vector_in` / `enqueue` / `eof_in` triplet directly. It frames the stream on end-of-frame markers, zero-pads partial vectors, and keeps simple statistics counters for host-side sanity checks.

---
 rtl/vector_assembler.sv | 153 +++++++++++++++
 tb/tb_vector_assembler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : vector_assembler
//  Description : Packs a scalar element stream (one element per cycle, no
//                backpressure) into N-lane vectors for the debugger input
//                port. Vectors close when the last lane is written, when an
//                element carries an end-of-frame flag, or on flush. Partial
//                vectors are zero-padded. Keeps emitted-vector and
//                inserted-pad-lane statistics.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   rising-edge clock
//    reset       in   asynchronous active-high reset
//    elem_in     in   scalar element
//    elem_valid  in   elem_in / elem_eof valid this cycle
//    elem_eof    in   [1:0] end-of-frame flags (bit0 inner, bit1 outer)
//    flush       in   force emission of a partially filled vector
//    vector_out  out  [N] x DATA_WIDTH emitted vector (held between pulses)
//    enqueue     out  one-cycle pulse qualifying vector_out / eof_out
//    eof_out     out  [1:0] end-of-frame flags of the emitted vector
//    lane_ptr    out  next lane to be written
//    vec_count   out  vectors emitted since reset (wrapping)
//    pad_count   out  zero lanes inserted since reset (saturating)
// ============================================================================
module vector_assembler #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] elem_in,
  input  logic                  elem_valid,
  input  logic [1:0]            elem_eof,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] vector_out [N],
  output logic                  enqueue,
  output logic [1:0]            eof_out,
  output logic [$clog2(N)-1:0]  lane_ptr,
  output logic [31:0]           vec_count,
  output logic [15:0]           pad_count
);

  localparam int              PTR_W    = $clog2(N);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(N - 1);
  localparam logic [16:0]     N_EXT    = 17'(N);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] asm_q [N];
  logic [DATA_WIDTH-1:0] asm_d [N];
  logic [DATA_WIDTH-1:0] vec_q [N];
  logic [DATA_WIDTH-1:0] vec_d [N];
  logic                  enq_q, enq_d;
  logic [1:0]            eof_q, eof_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [31:0]           vc_q,  vc_d;
  logic [15:0]           pc_q,  pc_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] merged [N];   // assembly lanes with this cycle's element written in
  logic                  close_elem;   // an absorbed element closes the vector
  logic                  close_flush;  // bare flush closes a non-empty vector
  logic [16:0]           pad_inc;
  logic [16:0]           pad_sum;

  always_comb begin
    close_elem  = elem_valid && ((ptr_q == LAST_LANE) || (elem_eof != 2'b00) || flush);
    // A bare flush on an empty assembler must not emit anything.
    close_flush = !elem_valid && flush && (ptr_q != '0);

    for (int i = 0; i < N; i++) begin
      merged[i] = (elem_valid && (PTR_W'(i) == ptr_q)) ? elem_in : asm_q[i];
    end

    asm_d   = asm_q;
    vec_d   = vec_q;
    eof_d   = eof_q;
    enq_d   = 1'b0;
    ptr_d   = ptr_q;
    vc_d    = vc_q;
    pc_d    = pc_q;
    pad_inc = '0;
    pad_sum = '0;

    if (close_elem || close_flush) begin
      // Lanes 0..ptr-1 are always occupied; lane ptr only when an element
      // arrived this cycle. Everything above is explicitly zeroed.
      for (int i = 0; i < N; i++) begin
        if ((PTR_W'(i) < ptr_q) || (close_elem && (PTR_W'(i) == ptr_q))) begin
          vec_d[i] = merged[i];
        end else begin
          vec_d[i] = '0;
        end
        asm_d[i] = '0;
      end
      eof_d = close_elem ? elem_eof : 2'b00;
      enq_d = 1'b1;
      ptr_d = '0;
      vc_d  = vc_q + 32'd1;

      // Pad lanes: N-1-ptr when the element occupies lane ptr, else N-ptr.
      pad_inc = N_EXT - 17'(ptr_q) - (close_elem ? 17'd1 : 17'd0);
      pad_sum = {1'b0, pc_q} + pad_inc;
      pc_d    = pad_sum[16] ? 16'hFFFF : pad_sum[15:0];
    end else if (elem_valid) begin
      asm_d = merged;
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers (reset discards any partial vector immediately)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        asm_q[i] <= '0;
        vec_q[i] <= '0;
      end
      enq_q <= 1'b0;
      eof_q <= 2'b00;
      ptr_q <= '0;
      vc_q  <= '0;
      pc_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        asm_q[i] <= asm_d[i];
        vec_q[i] <= vec_d[i];
      end
      enq_q <= enq_d;
      eof_q <= eof_d;
      ptr_q <= ptr_d;
      vc_q  <= vc_d;
      pc_q  <= pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all straight from flops
  // --------------------------------------------------------------------------
  assign vector_out = vec_q;
  assign enqueue    = enq_q;
  assign eof_out    = eof_q;
  assign lane_ptr   = ptr_q;
  assign vec_count  = vc_q;
  assign pad_count  = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_assembler
//  Description : Directed table-driven bench for vector_assembler (N=8,
//                DATA_WIDTH=32) plus hand-written sequences for pad-count
//                saturation and asynchronous reset mid-fill.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] elem_in;
  logic        elem_valid;
  logic [1:0]  elem_eof;
  logic        flush;
  logic [31:0] vector_out [8];
  logic        enqueue;
  logic [1:0]  eof_out;
  logic [2:0]  lane_ptr;
  logic [31:0] vec_count;
  logic [15:0] pad_count;

  vector_assembler #(.N(8), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_eof   (elem_eof),
    .flush      (flush),
    .vector_out (vector_out),
    .enqueue    (enqueue),
    .eof_out    (eof_out),
    .lane_ptr   (lane_ptr),
    .vec_count  (vec_count),
    .pad_count  (pad_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [31:0]      e;
    logic [1:0]       eof;
    logic             fl;
    logic             xenq;
    logic [2:0]       xptr;
    logic [7:0][31:0] xvec;
    logic [1:0]       xeof;
    logic [31:0]      xvc;
    logic [15:0]      xpc;
  } row_t;

  row_t             tbl[$];
  logic [7:0][31:0] held_vec;
  logic [1:0]       held_eof;
  int               tests = 0;
  int               fails = 0;

  function automatic logic [7:0][31:0] mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic logic [255:0] packv();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = vector_out[i];
    return p;
  endfunction

  // Expected vector / eof hold their last emitted values on non-enqueue rows.
  task automatic add(input logic v, input logic [31:0] e, input logic [1:0] eof,
                     input logic fl, input logic xenq, input logic [2:0] xptr,
                     input logic [7:0][31:0] xvec, input logic [1:0] xeof,
                     input logic [31:0] xvc, input logic [15:0] xpc);
    row_t r;
    if (xenq) begin
      held_vec = xvec;
      held_eof = xeof;
    end
    r.v = v; r.e = e; r.eof = eof; r.fl = fl; r.xenq = xenq; r.xptr = xptr;
    r.xvec = held_vec; r.xeof = held_eof; r.xvc = xvc; r.xpc = xpc;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] e, input logic [1:0] eof, input logic fl);
    elem_valid = v;
    elem_in    = e;
    elem_eof   = eof;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  logic [7:0][31:0] z;

  initial begin
    z          = '0;
    held_vec   = '0;
    held_eof   = 2'b00;
    reset      = 1'b1;
    elem_in    = '0;
    elem_valid = 1'b0;
    elem_eof   = 2'b00;
    flush      = 1'b0;

    // ---------------- table fill ----------------
    // 16 contiguous elements 1..16
    for (int i = 1; i <= 16; i++)
      add(1'b1, 32'(i), 2'b00, 1'b0, (i % 8) == 0, 3'(i % 8),
          (i == 8) ? mk(1,2,3,4,5,6,7,8) : mk(9,10,11,12,13,14,15,16),
          2'b00, 32'(i / 8), 16'd0);
    // 10, 20, 30 with inner eof on 30
    add(1'b1, 32'd10, 2'b00, 1'b0, 1'b0, 3'd1, z, 2'b00, 32'd2, 16'd0);
    add(1'b1, 32'd20, 2'b00, 1'b0, 1'b0, 3'd2, z, 2'b00, 32'd2, 16'd0);
    add(1'b1, 32'd30, 2'b01, 1'b0, 1'b1, 3'd0, mk(10,20,30,0,0,0,0,0), 2'b01, 32'd3, 16'd5);
    // 100..107 with 3 idle cycles between (idle eof must be ignored), eof 11 on lane 7
    for (int k = 0; k < 8; k++) begin
      add(1'b1, 32'(100 + k), (k == 7) ? 2'b11 : 2'b00, 1'b0, k == 7,
          (k == 7) ? 3'd0 : 3'(k + 1), mk(100,101,102,103,104,105,106,107), 2'b11,
          (k == 7) ? 32'd4 : 32'd3, 16'd5);
      if (k < 7)
        for (int j = 0; j < 3; j++)
          add(1'b0, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0, 3'(k + 1), z, 2'b00, 32'd3, 16'd5);
    end
    add(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 3'd0, z, 2'b00, 32'd4, 16'd5);   // no extra vector
    // flush while empty
    add(1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 3'd0, z, 2'b00, 32'd4, 16'd5);
    add(1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 3'd0, z, 2'b00, 32'd4, 16'd5);
    // 7, 8 then standalone flush
    add(1'b1, 32'd7, 2'b00, 1'b0, 1'b0, 3'd1, z, 2'b00, 32'd4, 16'd5);
    add(1'b1, 32'd8, 2'b00, 1'b0, 1'b0, 3'd2, z, 2'b00, 32'd4, 16'd5);
    add(1'b0, 32'd0, 2'b00, 1'b1, 1'b1, 3'd0, mk(7,8,0,0,0,0,0,0), 2'b00, 32'd5, 16'd11);
    // element 9 with flush in the same cycle
    add(1'b1, 32'd9, 2'b00, 1'b1, 1'b1, 3'd0, mk(9,0,0,0,0,0,0,0), 2'b00, 32'd6, 16'd18);
    // maximum rate: eof on every element
    add(1'b1, 32'd1, 2'b10, 1'b0, 1'b1, 3'd0, mk(1,0,0,0,0,0,0,0), 2'b10, 32'd7, 16'd25);
    add(1'b1, 32'd2, 2'b10, 1'b0, 1'b1, 3'd0, mk(2,0,0,0,0,0,0,0), 2'b10, 32'd8, 16'd32);
    // flush together with eof on lane 1: eof_out follows the element
    add(1'b1, 32'd5, 2'b00, 1'b0, 1'b0, 3'd1, z, 2'b00, 32'd8, 16'd32);
    add(1'b1, 32'd6, 2'b01, 1'b1, 1'b1, 3'd0, mk(5,6,0,0,0,0,0,0), 2'b01, 32'd9, 16'd38);

    // ---------------- reset state ----------------
    @(posedge clk); @(posedge clk); #1;
    chk("reset enqueue",    256'(enqueue),   256'd0);
    chk("reset vector_out", packv(),         256'd0);
    chk("reset eof_out",    256'(eof_out),   256'd0);
    chk("reset lane_ptr",   256'(lane_ptr),  256'd0);
    chk("reset vec_count",  256'(vec_count), 256'd0);
    chk("reset pad_count",  256'(pad_count), 256'd0);
    reset = 1'b0;

    // ---------------- table run ----------------
    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].v, tbl[r].e, tbl[r].eof, tbl[r].fl);
      chk($sformatf("row%0d enqueue", r),   256'(enqueue),   256'(tbl[r].xenq));
      chk($sformatf("row%0d lane_ptr", r),  256'(lane_ptr),  256'(tbl[r].xptr));
      chk($sformatf("row%0d vector", r),    packv(),         256'(tbl[r].xvec));
      chk($sformatf("row%0d eof_out", r),   256'(eof_out),   256'(tbl[r].xeof));
      chk($sformatf("row%0d vec_count", r), 256'(vec_count), 256'(tbl[r].xvc));
      chk($sformatf("row%0d pad_count", r), 256'(pad_count), 256'(tbl[r].xpc));
    end

    // ---------------- pad_count saturation ----------------
    // Each single-element eof vector adds 7 pad lanes; start at 38.
    for (int n = 1; n <= 9360; n++) begin
      step(1'b1, 32'(n), 2'b01, 1'b0);
      if (n == 9356) chk("pad below saturation", 256'(pad_count), 256'd65530);
      if (n == 9357) chk("pad saturates",        256'(pad_count), 256'h0FFFF);
    end
    step(1'b0, 32'd0, 2'b00, 1'b0);
    chk("pad stays saturated", 256'(pad_count), 256'h0FFFF);
    chk("vec_count after sat", 256'(vec_count), 256'd9369);

    // ---------------- reset mid-fill ----------------
    for (int n = 0; n < 5; n++) step(1'b1, 32'(200 + n), 2'b00, 1'b0);
    chk("pre-reset lane_ptr", 256'(lane_ptr), 256'd5);
    elem_valid = 1'b0;
    reset      = 1'b1;
    #1;
    chk("async reset lane_ptr",  256'(lane_ptr),  256'd0);
    chk("async reset vec_count", 256'(vec_count), 256'd0);
    chk("async reset pad_count", 256'(pad_count), 256'd0);
    chk("async reset vector",    packv(),         256'd0);
    @(posedge clk); #1;
    chk("reset no enqueue", 256'(enqueue), 256'd0);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 32'(50 + n), 2'b00, 1'b0);
      chk($sformatf("post-reset enqueue %0d", n), 256'(enqueue), 256'(n == 7));
    end
    chk("post-reset vector",    packv(),         256'(mk(50,51,52,53,54,55,56,57)));
    chk("post-reset eof_out",   256'(eof_out),   256'd0);
    chk("post-reset vec_count", 256'(vec_count), 256'd1);
    chk("post-reset pad_count", 256'(pad_count), 256'd0);
    step(1'b0, 32'd0, 2'b00, 1'b0);
    chk("post-reset single pulse", 256'(enqueue), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
